pulse_to_level_stretcher: RTL and testbench
===========================================

// Module: pulse_to_level_stretcher
// PURPOSE
//   Inverse of the level-to-pulse converter: turns a short synchronous pulse (rising edge) into an active output
//   level of programmable length, or held until acknowledged. Sits between the edge/pulse generators and slow
//   consumers (LEDs, external start/stop lines, the time-meter gate) in the pulse propagation time meter.
//   Enforces a minimum inactive gap between outputs and flags triggers it had to drop.
// PARAMETERS
//   CNT_W       8  width of hold-length input and internal counter
//   GAP_CYCLES  2  forced inactive cycles after each output level; 0 = no gap
//   RETRIGGER   0  1 = trigger while active restarts the hold; 0 = trigger while busy is dropped and flagged
//   INVERT_OUT  1  1 = o_Out active-low (idle high), 0 = active-high
// PORTS
//   i_Clk       in   1      system clock, 50 MHz, rising edge
//   i_Rst_n     in   1      asynchronous active-low reset
//   i_Pulse     in   1      synchronous trigger; rising edge = trigger, width irrelevant
//   i_Hold_Len  in   CNT_W  active length L in cycles, sampled at trigger; 0 = hold until i_Ack
//   i_Ack       in   1      releases output in ack mode; ignored otherwise
//   o_Out       out  1      stretched level, polarity per INVERT_OUT
//   o_Busy      out  1      high in any state other than IDLE
//   o_Missed    out  1      one-cycle pulse when a trigger is dropped
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, counter 0, o_Out inactive (=INVERT_OUT), o_Busy 0, o_Missed 0,
//     edge register r_Prev = 1 (input already high at reset release is not a trigger). Mid-operation reset aborts.
//   trig = i_Pulse & ~r_Prev, evaluated each edge. All outputs registered.
//   Latency: trig at edge k -> o_Out active from edge k to edge k+L (exactly L cycles active).
//   States:
//     IDLE:     trig & L!=0 -> HOLD (cnt=L-1); trig & L==0 -> WAIT_ACK.
//     HOLD:     cnt!=0 -> cnt-1; cnt==0 -> GAP (GAP_CYCLES>0) else IDLE, o_Out inactive.
//               trig: RETRIGGER=1 -> reload cnt=L-1 (or WAIT_ACK if L==0), no o_Missed;
//                     RETRIGGER=0 -> o_Missed, hold unaffected (also on the cnt==0 cycle).
//     WAIT_ACK: i_Ack -> GAP/IDLE as above, o_Out inactive from that edge.
//               trig with i_Ack in same cycle: ack wins, trig -> o_Missed (either RETRIGGER).
//               trig alone: RETRIGGER=1 ignored silently; RETRIGGER=0 -> o_Missed.
//     GAP:      o_Out inactive for GAP_CYCLES cycles, then IDLE; any trig -> o_Missed, dropped.
//   Counter: CNT_W bits, loaded with L-1, never wraps (stops at 0). Max active length 2^CNT_W-1.
//   i_Ack outside WAIT_ACK has no effect. i_Hold_Len changes between triggers have no effect.
//   o_Busy = (state != IDLE), registered with state.
// STRUCTURE
//   Shared include pulse_defs.vh: state codes (IDLE=2'd0, HOLD=2'd1, WAIT_ACK=2'd2, GAP=2'd3),
//     reused by the time-meter control FSM.
//   Sub-module rise_edge_detect (i_Clk, i_Rst_n, i_In, o_Rise; prev register resets to 1); one instance.
//   Remainder: single FSM + one shared down-counter used for both HOLD and GAP.
// TESTING (Tclk=20 ns, defaults unless stated)
//   1 Reset, i_Hold_Len=5, one-cycle i_Pulse -> o_Out low exactly 5 cycles, o_Busy 7 cycles, o_Missed never.
//   2 i_Pulse held high across reset release -> no output; later 0->1 edge -> normal 5-cycle output.
//   3 RETRIGGER=0, second edge 3 cycles after first -> one o_Missed pulse, output still 5 cycles;
//     RETRIGGER=1 same stimulus -> output 8 cycles total, no o_Missed.
//   4 i_Hold_Len=0, trigger, i_Ack after 20 cycles -> o_Out active 20 cycles, released at ack edge;
//     trig+ack same cycle -> release plus o_Missed.
//   5 Trigger during GAP -> o_Missed, no output; trigger first cycle after GAP -> accepted.
//   6 i_Rst_n low mid-HOLD (async, between edges) -> o_Out inactive, o_Busy 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/pulse_to_level_stretcher_pkg.sv
// Shared state codes and small helpers for the pulse stretcher.
// The state encoding is also used by the time-meter control FSM, so the codes are fixed.
package pulse_to_level_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // The output is driven only in the two "level asserted" states.
  function automatic logic state_is_active(input state_t st);
    return (st == ST_HOLD) || (st == ST_WAIT_ACK);
  endfunction

  function automatic logic out_level(input logic active, input logic invert);
    return active ^ invert;
  endfunction

endpackage

// File: rtl/pulse_to_level_stretcher_edge.sv
// Rising-edge detector; the history register resets high so a line already
// high at reset release does not count as a trigger.
module rise_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_In,
  output logic o_Rise
);

  logic r_Prev;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Prev <= 1'b1;
    end else begin
      r_Prev <= i_In;
    end
  end

  assign o_Rise = i_In & ~r_Prev;

endmodule

// File: rtl/pulse_to_level_stretcher.sv
// Stretches a trigger edge into an output level of i_Hold_Len cycles (or until
// i_Ack when the length is zero), followed by a forced inactive gap.
module pulse_to_level_stretcher
  import pulse_to_level_stretcher_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RETRIGGER  = 0,
  parameter int INVERT_OUT = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Pulse,
  input  logic [CNT_W-1:0] i_Hold_Len,
  input  logic             i_Ack,
  output logic             o_Out,
  output logic             o_Busy,
  output logic             o_Missed
);

  localparam logic             LP_RETRIG   = (RETRIGGER != 0);
  localparam logic             LP_INV      = (INVERT_OUT != 0);
  localparam logic [CNT_W-1:0] LP_GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam state_t           LP_END_ST   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_t           r_State;
  state_t           w_State_Next;
  logic [CNT_W-1:0] r_Cnt;
  logic [CNT_W-1:0] w_Cnt_Next;
  logic             r_Out;
  logic             r_Busy;
  logic             r_Missed;
  logic             w_Missed_Next;
  logic             w_Trig;
  logic             w_Len_Zero;
  logic [CNT_W-1:0] w_Len_Load;
  logic             w_Cnt_Zero;

  rise_edge_detect u_edge (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_In    (i_Pulse),
    .o_Rise  (w_Trig)
  );

  assign w_Len_Zero = (i_Hold_Len == '0);
  assign w_Len_Load = i_Hold_Len - CNT_W'(1);
  assign w_Cnt_Zero = (r_Cnt == '0);

  // One counter serves both the hold length and the gap length; it stops at zero.
  always_comb begin
    w_State_Next  = r_State;
    w_Cnt_Next    = r_Cnt;
    w_Missed_Next = 1'b0;

    case (r_State)
      ST_IDLE: begin
        if (w_Trig) begin
          if (w_Len_Zero) begin
            w_State_Next = ST_WAIT_ACK;
            w_Cnt_Next   = '0;
          end else begin
            w_State_Next = ST_HOLD;
            w_Cnt_Next   = w_Len_Load;
          end
        end
      end

      ST_HOLD: begin
        if (w_Trig && LP_RETRIG) begin
          if (w_Len_Zero) begin
            w_State_Next = ST_WAIT_ACK;
            w_Cnt_Next   = '0;
          end else begin
            w_Cnt_Next   = w_Len_Load;
          end
        end else begin
          w_Missed_Next = w_Trig;
          if (!w_Cnt_Zero) begin
            w_Cnt_Next = r_Cnt - CNT_W'(1);
          end else begin
            w_State_Next = LP_END_ST;
            w_Cnt_Next   = LP_GAP_LOAD;
          end
        end
      end

      ST_WAIT_ACK: begin
        // Release has priority; a trigger coinciding with the ack is always dropped.
        if (i_Ack) begin
          w_State_Next  = LP_END_ST;
          w_Cnt_Next    = LP_GAP_LOAD;
          w_Missed_Next = w_Trig;
        end else begin
          w_Missed_Next = w_Trig & ~LP_RETRIG;
        end
      end

      ST_GAP: begin
        w_Missed_Next = w_Trig;
        if (!w_Cnt_Zero) begin
          w_Cnt_Next = r_Cnt - CNT_W'(1);
        end else begin
          w_State_Next = ST_IDLE;
        end
      end

      default: begin
        w_State_Next = ST_IDLE;
        w_Cnt_Next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State  <= ST_IDLE;
      r_Cnt    <= '0;
      r_Out    <= LP_INV;
      r_Busy   <= 1'b0;
      r_Missed <= 1'b0;
    end else begin
      r_State  <= w_State_Next;
      r_Cnt    <= w_Cnt_Next;
      r_Out    <= out_level(state_is_active(w_State_Next), LP_INV);
      r_Busy   <= (w_State_Next != ST_IDLE);
      r_Missed <= w_Missed_Next;
    end
  end

  assign o_Out    = r_Out;
  assign o_Busy   = r_Busy;
  assign o_Missed = r_Missed;

endmodule

// File: tb/tb_pulse_to_level_stretcher.sv
// Bench for the pulse stretcher: two instances (drop vs. retrigger) share one
// stimulus and are compared every cycle against a timeline model.
module tb_pulse_to_level_stretcher;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse = 1'b0;
  logic [7:0] hold_len = 8'd5;
  logic       ack = 1'b0;

  logic out_d [2];
  logic busy_d [2];
  logic miss_d [2];

  always #10 clk = ~clk;

  pulse_to_level_stretcher #(
    .CNT_W(8), .GAP_CYCLES(GAP), .RETRIGGER(0), .INVERT_OUT(1)
  ) dut_drop (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pulse(pulse), .i_Hold_Len(hold_len),
    .i_Ack(ack), .o_Out(out_d[0]), .o_Busy(busy_d[0]), .o_Missed(miss_d[0])
  );

  pulse_to_level_stretcher #(
    .CNT_W(8), .GAP_CYCLES(GAP), .RETRIGGER(1), .INVERT_OUT(1)
  ) dut_retrig (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pulse(pulse), .i_Hold_Len(hold_len),
    .i_Ack(ack), .o_Out(out_d[1]), .o_Busy(busy_d[1]), .o_Missed(miss_d[1])
  );

  // Timeline model: edge index n, cycle at which the level ends, cycle at which the gap ends.
  int m_n = 0;
  bit m_prev = 1'b1;
  bit m_act [2] = '{1'b0, 1'b0};
  bit m_ackm [2] = '{1'b0, 1'b0};
  int m_end [2] = '{0, 0};
  int m_bend [2] = '{-100, -100};
  bit m_miss [2] = '{1'b0, 1'b0};

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0;
        m_prev = 1'b1;
        for (int r = 0; r < 2; r++) begin
          m_act[r] = 1'b0; m_ackm[r] = 1'b0; m_end[r] = 0;
          m_bend[r] = -100; m_miss[r] = 1'b0;
        end
      end else begin
        bit trig;
        trig = pulse && !m_prev;
        m_prev = pulse;
        m_n = m_n + 1;
        for (int r = 0; r < 2; r++) begin
          m_miss[r] = 1'b0;
          if (m_act[r] && m_ackm[r]) begin
            if (ack) begin
              m_act[r] = 1'b0;
              m_bend[r] = m_n + GAP;
              m_miss[r] = trig;
            end else if (trig && r == 0) begin
              m_miss[r] = 1'b1;
            end
          end else if (m_act[r]) begin
            if (trig && r == 1) begin
              if (hold_len == 0) m_ackm[r] = 1'b1;
              else m_end[r] = m_n + int'(hold_len);
            end else if (trig) begin
              m_miss[r] = 1'b1;
            end
            if (!m_ackm[r] && m_n >= m_end[r]) begin
              m_act[r] = 1'b0;
              m_bend[r] = m_n + GAP;
            end
          end else if (m_n <= m_bend[r]) begin
            m_miss[r] = trig;
          end else if (trig) begin
            m_act[r] = 1'b1;
            m_ackm[r] = (hold_len == 0);
            m_end[r] = m_n + int'(hold_len);
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int c_act [2] = '{0, 0};
  int c_busy [2] = '{0, 0};
  int c_miss [2] = '{0, 0};
  int b_act [2];
  int b_busy [2];
  int b_miss [2];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Per-cycle comparison against the model, plus active/busy/missed tallies.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("out%0d", r), out_d[r], !m_act[r]);
        chk($sformatf("busy%0d", r), busy_d[r], m_act[r] || (m_n < m_bend[r]));
        chk($sformatf("miss%0d", r), miss_d[r], m_miss[r]);
        if (rst_n) begin
          c_act[r] += (out_d[r] == 1'b0) ? 1 : 0;
          c_busy[r] += busy_d[r] ? 1 : 0;
          c_miss[r] += miss_d[r] ? 1 : 0;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int r = 0; r < 2; r++) begin
      b_act[r] = c_act[r]; b_busy[r] = c_busy[r]; b_miss[r] = c_miss[r];
    end
  endtask

  task automatic trig_once();
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic 5-cycle stretch; length change mid-hold must not matter.
    snap();
    trig_once();
    hold_len = 8'd9;
    tick(12);
    hold_len = 8'd5;
    chk_int("t1_act0", c_act[0] - b_act[0], 5);
    chk_int("t1_busy0", c_busy[0] - b_busy[0], 7);
    chk_int("t1_miss0", c_miss[0] - b_miss[0], 0);
    chk_int("t1_act1", c_act[1] - b_act[1], 5);

    // Input high across reset release is not a trigger.
    rst_n = 1'b0;
    pulse = 1'b1;
    tick(2);
    rst_n = 1'b1;
    snap();
    tick(6);
    chk_int("t2_noact", c_act[0] - b_act[0], 0);
    pulse = 1'b0;
    tick(2);
    snap();
    trig_once();
    tick(10);
    chk_int("t2_act0", c_act[0] - b_act[0], 5);

    // Second edge 3 cycles after the first.
    snap();
    trig_once();
    tick(2);
    trig_once();
    tick(15);
    chk_int("t3_act0", c_act[0] - b_act[0], 5);
    chk_int("t3_miss0", c_miss[0] - b_miss[0], 1);
    chk_int("t3_act1", c_act[1] - b_act[1], 8);
    chk_int("t3_miss1", c_miss[1] - b_miss[1], 0);
    chk_int("t3_busy1", c_busy[1] - b_busy[1], 10);

    // Ack mode: 20 active cycles.
    hold_len = 8'd0;
    snap();
    trig_once();
    tick(19);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(6);
    chk_int("t4_act0", c_act[0] - b_act[0], 20);
    chk_int("t4_act1", c_act[1] - b_act[1], 20);

    // Ack mode: lone trigger, then trigger together with ack.
    snap();
    trig_once();
    tick(1);
    trig_once();
    tick(2);
    pulse = 1'b1;
    ack = 1'b1;
    tick(1);
    pulse = 1'b0;
    ack = 1'b0;
    tick(6);
    chk_int("t4b_act0", c_act[0] - b_act[0], 5);
    chk_int("t4b_miss0", c_miss[0] - b_miss[0], 2);
    chk_int("t4b_miss1", c_miss[1] - b_miss[1], 1);

    // Trigger inside the gap is dropped; the first cycle after the gap is accepted.
    hold_len = 8'd3;
    snap();
    trig_once();
    tick(3);
    trig_once();
    tick(1);
    trig_once();
    tick(8);
    chk_int("t5_act0", c_act[0] - b_act[0], 6);
    chk_int("t5_miss0", c_miss[0] - b_miss[0], 1);
    chk_int("t5_miss1", c_miss[1] - b_miss[1], 1);
    chk_int("t5_busy0", c_busy[0] - b_busy[0], 10);

    // Trigger on the final hold cycle, with ack held high (no effect outside ack mode).
    ack = 1'b1;
    snap();
    trig_once();
    tick(2);
    trig_once();
    tick(10);
    ack = 1'b0;
    chk_int("t5b_act0", c_act[0] - b_act[0], 3);
    chk_int("t5b_miss0", c_miss[0] - b_miss[0], 1);
    chk_int("t5b_act1", c_act[1] - b_act[1], 6);
    chk_int("t5b_miss1", c_miss[1] - b_miss[1], 0);

    // Asynchronous reset between edges, mid-hold.
    hold_len = 8'd5;
    trig_once();
    tick(2);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t6_out0", out_d[0], 1'b1);
    chk("t6_busy0", busy_d[0], 1'b0);
    chk("t6_out1", out_d[1], 1'b1);
    chk("t6_busy1", busy_d[1], 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    snap();
    trig_once();
    tick(10);
    chk_int("t6_act0", c_act[0] - b_act[0], 5);
    chk_int("t6_busy0n", c_busy[0] - b_busy[0], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
